pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
- Stall/flush controller for the 5-stage pipeline; the counterpart to the bypass path.
- The forwarding unit resolves hazards that a bypass can satisfy. This block resolves the rest: load-use, jr-on-load, memory wait, taken-branch squash and halt.
- It drives enable and flush signals for the IF/ID, ID/EX, EX/MEM and MEM/WB latches and the PC enable.
- It keeps saturating stall and flush counters and runs a data-memory watchdog.

Parameters:
- CNT_W, 16, width of the stall_cnt and flush_cnt performance counters.
- TIMEOUT, 255, number of consecutive DWAIT cycles before mem_timeout asserts.

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  asynchronous, active-high reset.
- ihit  input  1  instruction memory returned the fetch this cycle.
- dhit  input  1  data memory completed the MEM-stage access this cycle.
- dmemreq_me  input  1  MEM-stage instruction issues a read or write (dREN|dWEN).
- memToReg_ex  input  1  EX-stage instruction is a load.
- regWr_ex  input  1  EX-stage instruction writes the register file.
- regDst_ex  input  5  EX-stage destination register.
- rs_de  input  5  decode rs field.
- rt_de  input  5  decode rt field.
- useRt_de  input  1  decode instruction reads rt.
- jr_de  input  1  decode instruction is jr.
- brTaken_me  input  1  branch/jump resolved taken in MEM.
- halt_wb  input  1  halt instruction reached WB.
- pcEn  output  1  PC register load enable.
- en_fd, en_de, en_em, en_mw  output  1 each  latch enables for IF/ID, ID/EX, EX/MEM, MEM/WB.
- flush_fd, flush_de, flush_em  output  1 each  synchronous bubble insertion; takes effect on the same edge as the enable.
- halted  output  1  sticky halt indicator.
- mem_timeout  output  1  sticky data-memory watchdog flag.
- stall_cnt  output  CNT_W  cycles with pcEn=0 while not halted.
- flush_cnt  output  CNT_W  count of taken-branch squash events.

Behaviour:
- FSM states: RUN, DWAIT, HALT, registered. Outputs are Mealy (state plus current inputs).
- Reset (async, RST=1):
  - State goes to RUN; counters, halted and mem_timeout clear to 0; watchdog counter clears to 0.
  - Outputs during reset: all enables 1, all flushes 0, pcEn 0.
- Hazard terms:
  - luHaz = memToReg_ex & regWr_ex & regDst_ex!=0 & (regDst_ex==rs_de | (useRt_de & regDst_ex==rt_de)).
  - jrHaz = jr_de & regWr_ex & memToReg_ex & regDst_ex==rs_de & regDst_ex!=0.
- Priority, highest first, evaluated each cycle:
  1. HALT state or halt_wb=1: all enables 0, flushes 0, pcEn 0, halted=1. Next state HALT, held until RST.
  2. dmemreq_me & !dhit: freeze. All enables 0, pcEn 0, flushes 0. Next state DWAIT.
  3. brTaken_me: pcEn 1, all enables 1, flush_fd=flush_de=flush_em=1. flush_cnt increments. Overrides luHaz, jrHaz and ihit wait.
  4. luHaz | jrHaz: pcEn 0, en_fd 0, flush_de 1 (one bubble into EX), en_em=en_mw=1. The load leaves EX the next cycle, so the stall lasts exactly 1 cycle.
  5. !ihit: pcEn 0, en_fd 0, flush_de 1, downstream latches advance.
  6. Otherwise: pcEn 1, all enables 1, no flush.
- DWAIT:
  - Outputs are the freeze of rule 2 while dhit=0.
  - On dhit=1: outputs are evaluated by rules 3–6 as in RUN, and next state is RUN. The completing cycle is not an extra stall.
- Watchdog:
  - Increments each cycle in DWAIT; clears on leaving DWAIT.
  - When it reaches TIMEOUT, mem_timeout=1 (sticky). The FSM keeps waiting.
- Counters:
  - stall_cnt += 1 on every cycle with pcEn=0 and state!=HALT, excluding reset.
  - Both counters saturate at all-ones; no wrap.
- Register $0 never causes a stall.
- A simultaneous luHaz and dmem wait produces a freeze only; the load-use bubble is re-evaluated after release.

Test Plan:
- lw $2 in EX (memToReg_ex=1, regDst_ex=2), rs_de=2 → exactly 1 cycle of pcEn=0, en_fd=0, flush_de=1; stall_cnt=1; the next cycle is normal.
- Same as above with regDst_ex=0 → no stall; stall_cnt=0.
- dmemreq_me=1, dhit held low 4 cycles → all enables 0 for 4 cycles, state DWAIT, stall_cnt=4. On the dhit cycle enables=1 and state returns to RUN.
- brTaken_me=1 coincident with luHaz=1 and ihit=0 → pcEn=1, flush_fd/de/em=1, flush_cnt=1, no stall counted.
- TIMEOUT=3, dhit low 5 cycles → mem_timeout rises after the 3rd DWAIT cycle and stays 1 after dhit.
- halt_wb pulse, then RST mid-halt → halted=1 and pcEn=0 sticky; RST clears halted, counters and state asynchronously.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: resolves load-use, jr-on-load,
// data-memory wait, taken-branch squash and halt; keeps perf counters and a memory watchdog.
module pipeline_hazard_ctrl #(
   parameter int CNT_W   = 16,
   parameter int TIMEOUT = 255
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             ihit,
   input  logic             dhit,
   input  logic             dmemreq_me,
   input  logic             memToReg_ex,
   input  logic             regWr_ex,
   input  logic [4:0]       regDst_ex,
   input  logic [4:0]       rs_de,
   input  logic [4:0]       rt_de,
   input  logic             useRt_de,
   input  logic             jr_de,
   input  logic             brTaken_me,
   input  logic             halt_wb,
   output logic             pcEn,
   output logic             en_fd,
   output logic             en_de,
   output logic             en_em,
   output logic             en_mw,
   output logic             flush_fd,
   output logic             flush_de,
   output logic             flush_em,
   output logic             halted,
   output logic             mem_timeout,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam int WD_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT);

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DWAIT = 2'd1,
      HALT  = 2'd2
   } state_t;

   state_t          state;
   state_t          state_next;
   logic [WD_W-1:0] wd;
   logic            lu_haz;
   logic            jr_haz;
   logic            halt_now;
   logic            freeze;
   logic            squash;
   logic            count_stall;

   assign lu_haz = memToReg_ex & regWr_ex & (regDst_ex != 5'd0) &
                   ((regDst_ex == rs_de) | (useRt_de & (regDst_ex == rt_de)));
   assign jr_haz = jr_de & regWr_ex & memToReg_ex & (regDst_ex == rs_de) & (regDst_ex != 5'd0);

   assign halt_now = (state == HALT) | halt_wb;
   // In DWAIT the freeze holds regardless of dmemreq_me; the pending access is still in MEM.
   assign freeze   = !halt_now & !dhit & ((state == DWAIT) | dmemreq_me);

   always_comb begin
      pcEn       = 1'b1;
      en_fd      = 1'b1;
      en_de      = 1'b1;
      en_em      = 1'b1;
      en_mw      = 1'b1;
      flush_fd   = 1'b0;
      flush_de   = 1'b0;
      flush_em   = 1'b0;
      squash     = 1'b0;
      state_next = RUN;
      if (RST) begin
         pcEn = 1'b0;
      end else if (halt_now) begin
         pcEn       = 1'b0;
         en_fd      = 1'b0;
         en_de      = 1'b0;
         en_em      = 1'b0;
         en_mw      = 1'b0;
         state_next = HALT;
      end else if (freeze) begin
         pcEn       = 1'b0;
         en_fd      = 1'b0;
         en_de      = 1'b0;
         en_em      = 1'b0;
         en_mw      = 1'b0;
         state_next = DWAIT;
      end else if (brTaken_me) begin
         flush_fd = 1'b1;
         flush_de = 1'b1;
         flush_em = 1'b1;
         squash   = 1'b1;
      end else if (lu_haz | jr_haz | !ihit) begin
         // Hold IF/ID and the PC, push one bubble into EX, let older stages drain.
         pcEn     = 1'b0;
         en_fd    = 1'b0;
         flush_de = 1'b1;
      end
   end

   assign halted      = !RST & halt_now;
   assign count_stall = !RST & !halt_now & !pcEn;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state       <= RUN;
         wd          <= '0;
         mem_timeout <= 1'b0;
         stall_cnt   <= '0;
         flush_cnt   <= '0;
      end else begin
         state <= state_next;
         if (count_stall && (stall_cnt != '1))
            stall_cnt <= stall_cnt + CNT_W'(1);
         if (squash && (flush_cnt != '1))
            flush_cnt <= flush_cnt + CNT_W'(1);
         if (state == DWAIT) begin
            if (wd != WD_MAX)
               wd <= wd + WD_W'(1);
            if (wd + WD_W'(1) == WD_MAX)
               mem_timeout <= 1'b1;
         end else begin
            wd <= '0;
         end
      end
   end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed and randomized check of pipeline_hazard_ctrl against a rule-level reference model.
module tb_pipeline_hazard_ctrl;

   localparam int CNT_W   = 4;
   localparam int TIMEOUT = 3;
   localparam int SAT     = (1 << CNT_W) - 1;

   logic CLK = 1'b0;
   logic RST = 1'b1;
   logic ihit, dhit, dmemreq_me, memToReg_ex, regWr_ex, useRt_de, jr_de, brTaken_me, halt_wb;
   logic [4:0] regDst_ex, rs_de, rt_de;
   logic pcEn, en_fd, en_de, en_em, en_mw, flush_fd, flush_de, flush_em, halted, mem_timeout;
   logic [CNT_W-1:0] stall_cnt, flush_cnt;

   pipeline_hazard_ctrl #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
      .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .dmemreq_me(dmemreq_me),
      .memToReg_ex(memToReg_ex), .regWr_ex(regWr_ex), .regDst_ex(regDst_ex),
      .rs_de(rs_de), .rt_de(rt_de), .useRt_de(useRt_de), .jr_de(jr_de),
      .brTaken_me(brTaken_me), .halt_wb(halt_wb),
      .pcEn(pcEn), .en_fd(en_fd), .en_de(en_de), .en_em(en_em), .en_mw(en_mw),
      .flush_fd(flush_fd), .flush_de(flush_de), .flush_em(flush_em),
      .halted(halted), .mem_timeout(mem_timeout),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   always #5 CLK = ~CLK;

   int n_cmp = 0;
   int n_mis = 0;

   // Reference model: pipeline halted?, waiting on data memory?, consecutive wait cycles.
   bit m_halt, m_wait, m_to;
   int m_wd, m_stall, m_flush;

   function automatic bit load_use();
      int d;
      if (!(memToReg_ex && regWr_ex) || regDst_ex == 5'd0) return 1'b0;
      d = int'(regDst_ex);
      return (int'(rs_de) == d) || (useRt_de && int'(rt_de) == d) || (jr_de && int'(rs_de) == d);
   endfunction

   function automatic bit halting();
      return m_halt || halt_wb;
   endfunction

   function automatic bit waiting();
      return !halting() && !dhit && (m_wait || dmemreq_me);
   endfunction

   // {pcEn, en_fd, en_de, en_em, en_mw, flush_fd, flush_de, flush_em, halted, mem_timeout}
   function automatic logic [9:0] expect_ctl();
      if (RST)            return 10'b0_1111_000_0_0;
      if (halting())      return {9'b0_0000_000_1, m_to};
      if (waiting())      return {9'b0_0000_000_0, m_to};
      if (brTaken_me)     return {9'b1_1111_111_0, m_to};
      if (load_use() || !ihit) return {9'b0_0111_010_0, m_to};
      return {9'b1_1111_000_0, m_to};
   endfunction

   function automatic int sat(input int v);
      return (v > SAT) ? SAT : v;
   endfunction

   task automatic model_reset();
      m_halt = 0; m_wait = 0; m_to = 0; m_wd = 0; m_stall = 0; m_flush = 0;
   endtask

   task automatic chk_val(input string tag, input int obs, input int exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check(input string tag);
      logic [9:0] obs, exp;
      obs = {pcEn, en_fd, en_de, en_em, en_mw, flush_fd, flush_de, flush_em, halted, mem_timeout};
      exp = expect_ctl();
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s ctl observed=%b expected=%b", tag, obs, exp);
      end
      chk_val({tag, "_stall"}, int'(stall_cnt), sat(m_stall));
      chk_val({tag, "_flush"}, int'(flush_cnt), sat(m_flush));
   endtask

   // Called at a falling edge with inputs already driven; ends at the next falling edge.
   task automatic step(input string tag);
      bit h, w, br_used, pc;
      #1;
      check(tag);
      h       = halting();
      w       = waiting();
      pc      = expect_ctl()[9];
      br_used = !h && !w && brTaken_me;
      @(posedge CLK);
      if (!h && !pc) m_stall++;
      if (br_used) m_flush++;
      if (m_wait) begin
         m_wd++;
         if (m_wd >= TIMEOUT) m_to = 1;
      end else begin
         m_wd = 0;
      end
      m_wait = w;
      if (h) m_halt = 1;
      @(negedge CLK);
   endtask

   // Reset asserted mid-cycle to exercise the asynchronous path; ends at a falling edge.
   task automatic do_reset(input string tag);
      #2 RST = 1'b1;
      #1;
      model_reset();
      check({tag, "_async"});
      @(posedge CLK);
      #1 check({tag, "_held"});
      @(negedge CLK);
      RST = 1'b0;
   endtask

   task automatic set_in(input bit ih, input bit dh, input bit dm, input bit mtr, input bit rw,
                         input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt,
                         input bit urt, input bit jr, input bit br, input bit hw);
      ihit = ih; dhit = dh; dmemreq_me = dm; memToReg_ex = mtr; regWr_ex = rw;
      regDst_ex = rd; rs_de = rs; rt_de = rt; useRt_de = urt; jr_de = jr;
      brTaken_me = br; halt_wb = hw;
   endtask

   task automatic idle();
      set_in(1, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);
   endtask

   initial begin
      idle();
      model_reset();
      #3 check("reset");
      @(negedge CLK);
      RST = 1'b0;

      // Load-use on rs: exactly one stall cycle
      set_in(1, 1, 0, 1, 1, 5'd2, 5'd2, 5'd7, 0, 0, 0, 0);
      step("lu_stall");
      chk_val("lu_cnt", int'(stall_cnt), 1);
      idle();
      step("lu_after");
      // Load into $0 never stalls
      set_in(1, 1, 0, 1, 1, 5'd0, 5'd0, 5'd0, 1, 0, 0, 0);
      step("r0_nostall");
      chk_val("r0_cnt", int'(stall_cnt), 1);
      // Load-use via rt, and jr on load
      set_in(1, 1, 0, 1, 1, 5'd9, 5'd3, 5'd9, 1, 0, 0, 0);
      step("lu_rt");
      set_in(1, 1, 0, 1, 1, 5'd9, 5'd9, 5'd0, 0, 1, 0, 0);
      step("jr_load");
      idle();
      step("idle");

      // Data-memory wait for 4 cycles, concurrent load-use must not add a bubble
      for (int i = 0; i < 4; i++) begin
         set_in(1, 0, 1, 1, 1, 5'd4, 5'd4, 5'd0, 0, 0, 0, 0);
         step("dwait");
      end
      set_in(1, 1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);
      step("dhit");
      chk_val("dwait_cnt", int'(stall_cnt), 7);
      idle();
      step("after_dwait");

      do_reset("rst1");
      // Branch squash overrides load-use and ifetch miss
      set_in(0, 1, 0, 1, 1, 5'd5, 5'd5, 5'd0, 0, 0, 1, 0);
      step("br_over");
      chk_val("br_flush_cnt", int'(flush_cnt), 1);
      chk_val("br_stall_cnt", int'(stall_cnt), 0);

      // Watchdog: dhit low for 5 cycles
      for (int i = 0; i < 5; i++) begin
         set_in(1, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);
         step("wd_wait");
      end
      set_in(1, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);
      step("wd_hit");
      chk_val("wd_sticky", int'(mem_timeout), 1);

      // Halt is sticky until reset
      set_in(1, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1);
      step("halt_pulse");
      for (int i = 0; i < 3; i++) begin
         set_in(0, 0, 1, 1, 1, 5'd1, 5'd1, 5'd1, 1, 0, 1, 0);
         step("halt_hold");
      end
      chk_val("halt_sticky", int'(halted), 1);
      do_reset("halt_rst");
      chk_val("halt_clear", int'(halted), 0);

      // Randomized traffic with periodic resets
      for (int n = 0; n < 600; n++) begin
         if (n % 75 == 74) do_reset("rnd_rst");
         set_in($urandom_range(0, 9) < 8, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0,
                5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                $urandom_range(0, 1) == 1, $urandom_range(0, 4) == 0,
                $urandom_range(0, 6) == 0, $urandom_range(0, 99) == 0);
         step("rnd");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
